// File: rtl/am_demod_pkg.sv
// Shared types and sizing helpers for the AM envelope demodulator.
package am_demod_pkg;

  localparam int SAMPLE_W = 16;

  typedef enum logic {
    FILL = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Wide enough that N * 32767 never wraps.
  function automatic int sum_width(input int avg_log2);
    return SAMPLE_W + avg_log2;
  endfunction

endpackage

// File: rtl/boxcar_avg.sv
// Moving-average of the last 2^AVG_LOG2 samples using a circular buffer and running sum.
module boxcar_avg
  import am_demod_pkg::*;
#(
  parameter int AVG_LOG2 = 5,
  parameter int SUM_W    = sum_width(AVG_LOG2)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr,
  input  logic                sub_en,
  input  logic [SAMPLE_W-1:0] sample,
  output logic [SAMPLE_W-1:0] avg
);

  localparam int N = 1 << AVG_LOG2;

  logic [SAMPLE_W-1:0] mem [N];
  logic [AVG_LOG2-1:0] wptr;
  logic [SUM_W-1:0]    sum;
  logic [SAMPLE_W-1:0] old;

  // While filling, whatever sits in the buffer is not part of the window.
  assign old = sub_en ? mem[wptr] : '0;
  assign avg = sum[SUM_W-1 -: SAMPLE_W];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum  <= '0;
      wptr <= '0;
    end else if (wr) begin
      sum  <= sum + SUM_W'(sample) - SUM_W'(old);
      wptr <= wptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr) mem[wptr] <= sample;
  end

endmodule

// File: rtl/am_demod.sv
// AM envelope detector: register, full-wave rectify, boxcar average, decimate.
module am_demod
  import am_demod_pkg::*;
#(
  parameter int AVG_LOG2 = 5,
  parameter int DEC      = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic signed [SAMPLE_W-1:0] am_in,
  input  logic                       in_valid,
  output logic        [SAMPLE_W-1:0] env_out,
  output logic                       out_valid,
  output logic                       filling
);

  localparam int N      = 1 << AVG_LOG2;
  localparam int DCW    = (DEC > 1) ? $clog2(DEC) : 1;
  localparam int STAGES = 1;

  function automatic logic [SAMPLE_W-1:0] rectify(input logic signed [SAMPLE_W-1:0] x);
    if (x == {1'b1, {(SAMPLE_W-1){1'b0}}}) return {1'b0, {(SAMPLE_W-1){1'b1}}};
    else if (x < 0)                        return SAMPLE_W'(-x);
    else                                   return SAMPLE_W'(x);
  endfunction

  logic [STAGES:0]             vld_pipe;
  logic signed [SAMPLE_W-1:0]  s1_data;
  logic [SAMPLE_W-1:0]         s2_mag;
  logic [SAMPLE_W-1:0]         avg;
  state_t                      state;
  logic [AVG_LOG2-1:0]         fill_cnt;
  logic [DCW-1:0]              dec_cnt;
  logic                        fire;
  logic                        wr;

  assign wr      = vld_pipe[1];
  assign filling = (state == FILL);

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      vld_pipe <= '0;
      s1_data  <= '0;
      s2_mag   <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:0], in_valid};
      s1_data  <= am_in;
      s2_mag   <= rectify(s1_data);
    end
  end

  boxcar_avg #(.AVG_LOG2(AVG_LOG2)) u_boxcar (
    .clk    (clk),
    .rst    (rst_n),
    .wr     (wr),
    .sub_en (state == RUN),
    .sample (s2_mag),
    .avg    (avg)
  );

  // fire marks the edge the sum absorbed the DEC-th sample; the average is
  // captured one edge later, once that sum is visible.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state     <= FILL;
      fill_cnt  <= '0;
      dec_cnt   <= '0;
      fire      <= 1'b0;
      out_valid <= 1'b0;
      env_out   <= '0;
    end else begin
      out_valid <= fire;
      if (fire) env_out <= avg;
      fire <= 1'b0;
      if (wr) begin
        case (state)
          FILL: begin
            if (fill_cnt == AVG_LOG2'(N - 1)) begin
              state    <= RUN;
              fill_cnt <= '0;
            end else begin
              fill_cnt <= fill_cnt + 1'b1;
            end
          end
          RUN: begin
            if (dec_cnt == DCW'(DEC - 1)) begin
              dec_cnt <= '0;
              fire    <= 1'b1;
            end else begin
              dec_cnt <= dec_cnt + 1'b1;
            end
          end
          default: state <= FILL;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_am_demod.sv
// Scoreboard bench for am_demod: a window model predicts every strobe's value and cycle.
module tb_am_demod;

  localparam int AVG_LOG2 = 5;
  localparam int N        = 1 << AVG_LOG2;
  localparam int DEC      = 32;

  logic               clk = 1'b0;
  logic               rst_n = 1'b1;
  logic signed [15:0] am_in = '0;
  logic               in_valid = 1'b0;
  logic [15:0]        env_out;
  logic               out_valid;
  logic               filling;

  always #5 clk = ~clk;

  am_demod #(.AVG_LOG2(AVG_LOG2), .DEC(DEC)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .am_in     (am_in),
    .in_valid  (in_valid),
    .env_out   (env_out),
    .out_valid (out_valid),
    .filling   (filling)
  );

  typedef struct {
    int          val;
    int unsigned cyc;
  } exp_t;

  int          total = 0;
  int          bad = 0;
  int unsigned cyc = 0;
  exp_t        sb[$];
  int          win[$];
  int          m_fill = 0;
  int          m_dec = 0;
  logic [15:0] last_env = '0;

  always @(posedge clk) cyc++;

  function automatic int rect(input int x);
    if (x == -32768) return 32767;
    return (x < 0) ? -x : x;
  endfunction

  task automatic model_reset();
    win.delete();
    sb.delete();
    m_fill   = 0;
    m_dec    = 0;
    last_env = '0;
  endtask

  // Drive one sample at the falling edge; it is accepted on the next rising
  // edge and, if it completes a decimation period, appears three edges later.
  task automatic drive(input int v, input bit vld);
    int s;
    @(negedge clk);
    am_in    = 16'(v);
    in_valid = vld;
    if (vld) begin
      win.push_back(rect(v));
      if (win.size() > N) void'(win.pop_front());
      if (m_fill < N) m_fill++;
      else begin
        m_dec++;
        if (m_dec == DEC) begin
          m_dec = 0;
          s = 0;
          foreach (win[i]) s += win[i];
          sb.push_back('{s / N, cyc + 4});
        end
      end
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      total++;
      if (out_valid) begin
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL unexpected_strobe cyc=%0d env_out=%0d", cyc, env_out);
        end else begin
          exp_t e;
          e = sb.pop_front();
          if (env_out !== 16'(e.val) || cyc !== e.cyc) begin
            bad++;
            $display("FAIL strobe got env=%0d at cyc %0d, want env=%0d at cyc %0d",
                     env_out, cyc, e.val, e.cyc);
          end
        end
        last_env = env_out;
      end else if (env_out !== last_env) begin
        bad++;
        $display("FAIL env_hold got %0d want %0d", env_out, last_env);
      end
    end
  end

  task automatic drain(input string name);
    repeat (8) drive(0, 1'b0);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL %s_drain pending=%0d want 0", name, sb.size());
    end
  endtask

  task automatic do_reset(input string name);
    @(negedge clk);
    in_valid = 1'b0;
    #2 rst_n = 1'b1;
    #1;
    model_reset();
    total += 3;
    if (env_out !== 16'd0)  begin bad++; $display("FAIL %s_env got %0d want 0", name, env_out); end
    if (out_valid !== 1'b0) begin bad++; $display("FAIL %s_ovalid got %b want 0", name, out_valid); end
    if (filling !== 1'b1)   begin bad++; $display("FAIL %s_filling got %b want 1", name, filling); end
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
  endtask

  task automatic test_reset();
    do_reset("reset");
  endtask

  task automatic test_const();
    do_reset("const_rst");
    repeat (N) drive(1000, 1'b1);
    repeat (2) drive(1000, 1'b1);
    total++;
    if (filling !== 1'b1) begin bad++; $display("FAIL fill_hold got %b want 1", filling); end
    drive(1000, 1'b1);
    total++;
    if (filling !== 1'b0) begin bad++; $display("FAIL fill_fall got %b want 0", filling); end
    repeat (3 * DEC) drive(1000, 1'b1);
    drain("const");
  endtask

  task automatic test_alternating();
    do_reset("alt_rst");
    for (int i = 0; i < N + 3 * DEC; i++) drive((i % 2) ? -4000 : 4000, 1'b1);
    drain("alt");
  endtask

  task automatic test_min_value();
    do_reset("min_rst");
    repeat (N + 2 * DEC) drive(-32768, 1'b1);
    drain("min");
  endtask

  task automatic test_gaps();
    do_reset("gap_rst");
    for (int i = 0; i < 2 * (N + 3 * DEC); i++) drive(1000, (i % 2) == 0);
    drain("gap");
  endtask

  task automatic test_step();
    do_reset("step_rst");
    repeat (N + 40) drive(0, 1'b1);
    repeat (3 * DEC) drive(2000, 1'b1);
    drain("step");
  endtask

  task automatic test_mid_reset();
    do_reset("mid_rst0");
    repeat (N + DEC + 10) drive(1000, 1'b1);
    do_reset("mid_rst");
    repeat (N + 2 * DEC) drive(1000, 1'b1);
    drain("mid");
  endtask

  initial begin
    test_reset();
    test_const();
    test_alternating();
    test_min_value();
    test_gaps();
    test_step();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/am_demod.md
AM_DEMOD -- requirements
Module: am_demod

Interface
REQ-001 Parameter AVG_LOG2, default 5, meaning log2 of moving-average window length; window N = 2^AVG_LOG2, legal range 2..8.
REQ-002 Parameter DEC, default 32, meaning decimation ratio (accepted samples per output sample), legal range 1..1024.
REQ-003 Port clk  input  1  the single clock; all state is updated on its rising edge.
REQ-004 Port rst_n  input  1  reset; asynchronous, active-high; the port name is fixed despite the suffix.
REQ-005 Port am_in  input  16  signed two's-complement AM sample, i.e. the product output of the modulator.
REQ-006 Port in_valid  input  1  am_in is accepted on any rising edge where in_valid=1; tie high for a continuous stream.
REQ-007 Port env_out  output  16  unsigned demodulated envelope.
REQ-008 Port out_valid  output  1  one-cycle strobe; env_out holds a new sample in that cycle.
REQ-009 Port filling  output  1  high while the averaging window is not yet full.

Function
REQ-010 Stage 1 shall register am_in and in_valid, unconditionally, every cycle.
REQ-011 Stage 2 shall full-wave rectify: |x| as 16-bit unsigned, with -32768 saturating to 32767.
REQ-012 Stage 3 shall maintain a running sum of width 16+AVG_LOG2 over the last N rectified samples, using an N-entry circular buffer and a write pointer that wraps from N-1 to 0.
REQ-013 State FILL: each valid sample is written to the buffer and added to the sum, with no subtraction; a fill counter increments.
REQ-014 Transition FILL->RUN shall occur on the edge that writes the N-th sample; filling shall deassert in the same cycle.
REQ-015 State RUN: each valid sample shall update sum = sum + new - buffer[wptr] and then overwrite buffer[wptr], all in one cycle.
REQ-016 Buffer contents are never cleared; the FILL no-subtract rule makes stale contents irrelevant.
REQ-017 The average shall be sum >> AVG_LOG2, truncated with no rounding; it always fits 16 bits.
REQ-018 The decimation counter shall count valid samples only in RUN, over 0..DEC-1, and wrap to 0.
REQ-019 out_valid shall pulse and env_out shall load the average on the cycle after the sum update in which the counter wraps.
REQ-020 The first out_valid shall occur DEC samples after entering RUN.
REQ-021 Latency: a sample accepted at edge k shall be reflected in the sum at edge k+2 and in env_out at edge k+3, when that sample triggers output.
REQ-022 Cycles with in_valid=0 shall change no buffer, sum, counter or state, and shall produce no out_valid.
REQ-023 env_out shall hold its value between strobes.
REQ-024 The sum shall never wrap: its width guarantees N*32767 fits.

Reset
REQ-025 Assertion of rst_n shall asynchronously clear all pipeline registers, the sum, wptr, the fill counter and the decimation counter, and force state=FILL.
REQ-026 Reset values shall be env_out=0, out_valid=0, filling=1.
REQ-027 Reset mid-operation shall discard the window; after release, the block shall refill N samples before any output.
REQ-028 Deassertion shall take effect on the next rising edge of clk with no extra delay cycles.

Structure
REQ-029 A shared package shall hold the state enumeration (FILL, RUN), SAMPLE_W=16, and the function computing sum width from AVG_LOG2.
REQ-030 The circular buffer plus running-sum logic shall be one sub-module, boxcar_avg; rectification, decimation and the FSM stay in am_demod.

Verification
REQ-031 Constant am_in=1000 with in_valid=1: filling falls after 32 samples; out_valid pulses every 32 cycles; env_out=1000.
REQ-032 Alternating +4000/-4000 stream: env_out=4000 at every strobe.
REQ-033 Constant am_in=-32768: env_out=32767 with no overflow.
REQ-034 Same stream as REQ-031 but with in_valid toggled 1/0: out_valid spacing doubles to 64 cycles; env_out=1000.
REQ-035 Step from 0 to 2000 in RUN: the first strobe after the step reads the partial average (k*2000)>>5; the value is 2000 once 32 new samples have arrived.
REQ-036 Pulse rst_n mid-RUN: env_out=0 and filling=1 immediately; no out_valid until 32+32 samples after release.
